int_ctrl: RTL and testbench

//  Parametrised vectored interrupt controller; successor to the fixed two-source scheme (int_reg/shield/IF/int_chart).

---
 rtl/int_ctrl.sv | 134 +++++++++++++
 tb/tb_int_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge latch, mask/IF gating, fixed priority (ch0 highest).
// Ports: clk/reset, irq_in, mask_set/clr, if_set/clear, int_ack/eoi -> int_req/num/vec, status.
module int_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h80,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 8'h04,
  parameter bit AUTO_IF_CLR = 1'b1,
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] mask_set,
  input  logic [NUM_IRQ-1:0] mask_clr,
  input  logic               if_set,
  input  logic               if_clear,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               int_req,
  output logic [IDX_W-1:0]   int_num,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               if_out,
  output logic               in_service,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             st;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_bits;
  logic [IDX_W-1:0]   winner;
  logic               any_elig;
  logic               accept;

  function automatic logic [VEC_W-1:0] vec_of(
    input logic [IDX_W-1:0] n
  );
    return VEC_BASE + VEC_W'(n) * VEC_STRIDE;
  endfunction

  assign state    = st;
  assign edges    = irq_in & ~irq_q;
  assign eligible = pending & mask;
  assign any_elig = |eligible;
  assign accept   = (st == REQ) && int_ack && any_elig;

  // Scan high to low so the lowest set index ends up as winner.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    clr_bits = '0;
    if (accept) clr_bits[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      if_out     <= 1'b0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_num    <= '0;
      int_vec    <= '0;
      st         <= IDLE;
    end else begin
      irq_q   <= irq_in;
      // A fresh edge beats the accept-clear on the same bit.
      pending <= (pending & ~clr_bits) | edges;
      mask    <= (mask | mask_set) & ~mask_clr;

      if (if_clear)    if_out <= 1'b0;
      else if (if_set) if_out <= 1'b1;
      if (accept && AUTO_IF_CLR) if_out <= 1'b0;

      case (st)
        REQ: begin
          if (accept) begin
            st         <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
            int_num    <= winner;
            int_vec    <= vec_of(winner);
          end else if (!any_elig || !if_out) begin
            st      <= IDLE;
            int_req <= 1'b0;
            int_num <= '0;
            int_vec <= '0;
          end else begin
            int_num <= winner;
            int_vec <= vec_of(winner);
          end
        end
        SERVICE: begin
          if (int_eoi) begin
            st         <= IDLE;
            in_service <= 1'b0;
            int_num    <= '0;
            int_vec    <= '0;
          end
        end
        default: begin
          if (if_out && any_elig) begin
            st      <= REQ;
            int_req <= 1'b1;
            int_num <= winner;
            int_vec <= vec_of(winner);
          end else begin
            st      <= IDLE;
            int_req <= 1'b0;
            int_num <= '0;
            int_vec <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios plus random traffic
// checked each cycle against a behavioural model.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in, mask_set, mask_clr;
  logic       if_set, if_clear, int_ack, int_eoi;
  logic       int_req, if_out, in_service;
  logic [2:0] int_num;
  logic [7:0] int_vec, pending, mask;
  logic [1:0] state;

  logic       r4, ifs4, ifc4, ack4, eoi4;
  logic [3:0] irq4, ms4, mc4;
  logic       req4, if4, svc4;
  logic [1:0] num4, st4;
  logic [7:0] vec4;
  logic [3:0] pend4, mask4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .mask_set(mask_set), .mask_clr(mask_clr),
    .if_set(if_set), .if_clear(if_clear),
    .int_ack(int_ack), .int_eoi(int_eoi),
    .int_req(int_req), .int_num(int_num),
    .int_vec(int_vec), .pending(pending),
    .mask(mask), .if_out(if_out),
    .in_service(in_service), .state(state)
  );

  int_ctrl #(
    .NUM_IRQ(4), .VEC_BASE(8'hF8), .VEC_STRIDE(8'h04)
  ) dut4 (
    .clk(clk), .reset(r4), .irq_in(irq4),
    .mask_set(ms4), .mask_clr(mc4),
    .if_set(ifs4), .if_clear(ifc4),
    .int_ack(ack4), .int_eoi(eoi4),
    .int_req(req4), .int_num(num4),
    .int_vec(vec4), .pending(pend4),
    .mask(mask4), .if_out(if4),
    .in_service(svc4), .state(st4)
  );

  // Behavioural model: 0 idle, 1 requesting, 2 in service.
  int unsigned m_pend, m_mask, m_irqq;
  int          m_st, m_num, m_vec;
  bit          m_if, m_req, m_svc;

  function automatic int lowest(int unsigned v);
    for (int i = 0; i < 8; i++)
      if (((v >> i) & 1) != 0) return i;
    return 0;
  endfunction

  function automatic int vec_for(int n);
    return (128 + n * 4) % 256;
  endfunction

  task automatic model_step();
    int unsigned elig, np, nm, edges;
    int w;
    bit acc, nif;
    elig  = m_pend & m_mask;
    w     = lowest(elig);
    edges = irq_in & ~m_irqq & 8'hFF;
    acc   = (m_st == 1) && int_ack && (elig != 0);
    np = m_pend;
    if (acc) np = np & ~(1 << w);
    np = np | edges;
    nm = (m_mask | mask_set) & ~mask_clr & 8'hFF;
    nif = if_clear ? 1'b0 : (if_set ? 1'b1 : m_if);
    if (acc) nif = 1'b0;
    if (m_st == 1) begin
      if (acc) begin
        m_st = 2; m_req = 0; m_svc = 1;
        m_num = w; m_vec = vec_for(w);
      end else if (elig == 0 || !m_if) begin
        m_st = 0; m_req = 0; m_num = 0; m_vec = 0;
      end else begin
        m_num = w; m_vec = vec_for(w);
      end
    end else if (m_st == 2) begin
      if (int_eoi) begin
        m_st = 0; m_svc = 0; m_num = 0; m_vec = 0;
      end
    end else begin
      if (m_if && elig != 0) begin
        m_st = 1; m_req = 1;
        m_num = w; m_vec = vec_for(w);
      end else begin
        m_req = 0; m_num = 0; m_vec = 0;
      end
    end
    m_pend = np; m_mask = nm; m_if = nif;
    m_irqq = irq_in;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_irqq = 0; m_if = 0;
      m_req = 0; m_svc = 0; m_num = 0; m_vec = 0;
      m_st = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("req",   32'(int_req),    32'(m_req));
    chk("num",   32'(int_num),    m_num);
    chk("vec",   32'(int_vec),    m_vec);
    chk("pend",  32'(pending),    m_pend);
    chk("mask",  32'(mask),       m_mask);
    chk("if",    32'(if_out),     32'(m_if));
    chk("svc",   32'(in_service), 32'(m_svc));
    chk("state", 32'(state),      m_st);
    reset = 0; mask_set = 0; mask_clr = 0;
    if_set = 0; if_clear = 0; int_ack = 0; int_eoi = 0;
    r4 = 0; ms4 = 0; mc4 = 0; ifs4 = 0;
    ack4 = 0; eoi4 = 0;
  endtask

  initial begin
    reset = 1; irq_in = 0; mask_set = 0; mask_clr = 0;
    if_set = 0; if_clear = 0; int_ack = 0; int_eoi = 0;
    r4 = 1; irq4 = 0; ms4 = 0; mc4 = 0;
    ifs4 = 0; ifc4 = 0; ack4 = 0; eoi4 = 0;
    m_pend = 0; m_mask = 0; m_irqq = 0; m_st = 0;
    m_num = 0; m_vec = 0; m_if = 0; m_req = 0; m_svc = 0;
    #2;

    // reset state
    reset = 1; r4 = 1; tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_pend", 32'(pending), 0);

    // 1: ch3 request, vector 8C
    mask_set = 8'h08; if_set = 1;
    ms4 = 4'h8; ifs4 = 1; tick();
    irq_in = 8'h08; irq4 = 4'h8; tick();
    chk("t1_pend", 32'(pending), 32'h08);
    tick();
    chk("t1_req", 32'(int_req), 1);
    chk("t1_num", 32'(int_num), 3);
    chk("t1_vec", 32'(int_vec), 32'h8C);
    // 7: 4-channel wrap, ch3 -> F8+0C = 04
    chk("t7_req", 32'(req4), 1);
    chk("t7_num", 32'(num4), 3);
    chk("t7_vec", 32'(vec4), 32'h04);

    // 2: accept then eoi
    int_ack = 1; tick();
    chk("t2_state", 32'(state), 2);
    chk("t2_pend", 32'(pending), 0);
    chk("t2_if", 32'(if_out), 0);
    chk("t2_req", 32'(int_req), 0);
    int_eoi = 1; tick();
    chk("t2_idle", 32'(state), 0);
    tick();
    chk("t2_noreq", 32'(int_req), 0);

    // 3: ch5 and ch2 together, ch2 wins
    mask_set = 8'hFF; if_set = 1; tick();
    irq_in = 8'h2C; tick(); tick();
    chk("t3_num", 32'(int_num), 2);
    chk("t3_vec", 32'(int_vec), 32'h88);
    int_ack = 1; tick();
    int_eoi = 1; tick();
    if_set = 1; tick(); tick();
    chk("t3_num5", 32'(int_num), 5);
    chk("t3_vec5", 32'(int_vec), 32'h94);

    // 4: ch1 preempts ch5 before ack
    irq_in = 8'h2E; tick(); tick();
    chk("t4_num", 32'(int_num), 1);
    int_ack = 1; tick();
    chk("t4_lat", 32'(int_num), 1);
    chk("t4_pend", 32'(pending), 32'h20);
    int_eoi = 1; tick();

    // 5: masked pending is held
    irq_in = 0; reset = 1; tick();
    if_set = 1; mask_set = 8'hEF; tick();
    irq_in = 8'h10; tick(); tick();
    chk("t5_pend", 32'(pending), 32'h10);
    chk("t5_noreq", 32'(int_req), 0);
    mask_set = 8'h10; tick(); tick();
    chk("t5_req", 32'(int_req), 1);
    chk("t5_num", 32'(int_num), 4);
    mask_set = 8'h10; mask_clr = 8'h10; tick();
    chk("t5_clrwin", 32'(mask), 32'hEF);
    tick();
    chk("t5_drop", 32'(int_req), 0);

    // 6: reset while in service
    mask_set = 8'h10; tick(); tick();
    int_ack = 1; tick();
    chk("t6_svc", 32'(in_service), 1);
    reset = 1; tick();
    chk("t6_state", 32'(state), 0);
    chk("t6_svc0", 32'(in_service), 0);
    chk("t6_mask", 32'(mask), 0);
    int_eoi = 1; tick();
    chk("t6_eoi", 32'(state), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        irq_in = 8'($urandom());
      if ($urandom_range(0, 7) == 0)
        mask_set = 8'($urandom());
      if ($urandom_range(0, 15) == 0)
        mask_clr = 8'($urandom());
      if_set   = ($urandom_range(0, 3) == 0);
      if_clear = ($urandom_range(0, 15) == 0);
      int_ack  = ($urandom_range(0, 2) == 0);
      int_eoi  = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
